collision_damage: RTL

COLLISION_DAMAGE -- requirements
Module: collision_damage

---
 rtl/collision_damage.sv | 87 ++++++++
 1 files changed

// File: rtl/collision_damage.sv
// collision_damage: bullet scan, overlap test and hp/invulnerability tracking; COLLIDE_HEAL_EN enables green healing
module collision_damage #(
  parameter int N_BULLET = 3,
  parameter int HP_MAX = 20,
  parameter int DMG = 4,
  parameter int HEAL = 2,
  parameter int INVULN_CYCLES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isRun,
  output logic [2:0]  index,
  input  logic [15:0] position,
  input  logic [15:0] size,
  input  logic [1:0]  color,
  input  logic        isRender,
  input  logic [15:0] player_pos,
  input  logic [15:0] player_size,
  input  logic        player_moving,
  output logic        isCollide,
  output logic [7:0]  hp,
  output logic        isDead,
  output logic        invuln
);
  localparam int CW = $clog2(INVULN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SCAN, DEAD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] index_n;
  logic [7:0] hp_n, hp_dmg, hp_heal;
  logic [8:0] hp_sum;
  logic col_n, overlap, dmg_hit, heal_hit, hit_ok;
  assign overlap = isRender &&
    ({1'b0, player_pos[15:8]} < {1'b0, position[15:8]} + {1'b0, size[15:8]}) &&
    ({1'b0, position[15:8]} < {1'b0, player_pos[15:8]} + {1'b0, player_size[15:8]}) &&
    ({1'b0, player_pos[7:0]} < {1'b0, position[7:0]} + {1'b0, size[7:0]}) &&
    ({1'b0, position[7:0]} < {1'b0, player_pos[7:0]} + {1'b0, player_size[7:0]});
`ifdef COLLIDE_HEAL_EN
  assign dmg_hit = overlap && (color == 2'b00 || (color == 2'b10 && player_moving));
  assign heal_hit = overlap && color == 2'b01;
`else
  assign dmg_hit = overlap && (color == 2'b00 || color == 2'b01 || (color == 2'b10 && player_moving));
  assign heal_hit = 1'b0;
`endif
  assign invuln = cnt != '0;
  assign isDead = state == DEAD;
  assign hit_ok = (dmg_hit && !invuln) || heal_hit;
  assign hp_dmg = hp >= 8'(DMG) ? hp - 8'(DMG) : 8'd0;
  assign hp_sum = {1'b0, hp} + 9'(HEAL);
  assign hp_heal = hp_sum > 9'(HP_MAX) ? 8'(HP_MAX) : hp_sum[7:0];
  // next-state: scan and score hits while running, freeze when dead, otherwise reload to idle
  always_comb begin
    state_n = state;
    index_n = index;
    hp_n = hp;
    cnt_n = cnt;
    col_n = 1'b0;
    if (state == SCAN && isRun) begin
      index_n = index == 3'(N_BULLET - 1) ? 3'd0 : index + 3'd1;
      col_n = hit_ok;
      hp_n = !hit_ok ? hp : heal_hit ? hp_heal : hp_dmg;
      cnt_n = (hit_ok && !heal_hit) ? CW'(INVULN_CYCLES) : invuln ? cnt - 1'b1 : cnt;
      state_n = hp_n == 8'd0 ? DEAD : SCAN;
    end else if (!(state == DEAD && isRun)) begin
      state_n = (state == IDLE && isRun) ? SCAN : IDLE;
      index_n = '0;
      hp_n = 8'(HP_MAX);
      cnt_n = '0;
    end
  end
  // state register with synchronous reset overriding any hit in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      hp <= 8'(HP_MAX);
      cnt <= '0;
      isCollide <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      hp <= hp_n;
      cnt <= cnt_n;
      isCollide <= col_n;
    end
  end
endmodule
